mem_wb_stage: RTL



---
 rtl/mem_wb_stage_pkg.sv | 17 +
 rtl/mem_wb_stage_load_ext.sv | 26 ++
 rtl/mem_wb_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory/write-back boundary:
// write-back source selects and load funct3 codes.
package mem_wb_stage_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_D  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;
   localparam logic [2:0] LD_WU = 3'b110;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load data extension: trims a raw little-endian load
// to byte/half/word and sign- or zero-extends it.
module mem_wb_stage_load_ext
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_data,
   output logic [XLEN-1:0] o_data
);

   always_comb begin
      o_data = i_data;
      case (i_funct3)
         LD_B:  o_data = {{(XLEN-8){i_data[7]}}, i_data[7:0]};
         LD_H:  o_data = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
         LD_W:  o_data = {{(XLEN-32){i_data[31]}}, i_data[31:0]};
         LD_BU: o_data = {{(XLEN-8){1'b0}}, i_data[7:0]};
         LD_HU: o_data = {{(XLEN-16){1'b0}}, i_data[15:0]};
         LD_WU: o_data = {{(XLEN-32){1'b0}}, i_data[31:0]};
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extends loads, drives the
// register-file write port, EX bypass and retire counter.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 64
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   input  logic [1:0]       wb_select,
   input  logic [XLEN-1:0]  write_back_data,
   input  logic [2:0]       load_funct3,
   input  logic [4:0]       rd,
   input  logic             reg_write,
   input  logic             stall,
   input  logic             flush,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic             retire,
   output logic [CNT_W-1:0] instret
);

   logic [XLEN-1:0]  w_load;
   logic [XLEN-1:0]  w_ext;
   logic             w_wr_ok;

   logic             r_valid;
   logic             r_fresh;
   logic             r_reg_write;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_data;
   logic [CNT_W-1:0] r_instret;

   mem_wb_stage_load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .i_funct3 (load_funct3),
      .i_data   (write_back_data),
      .o_data   (w_load)
   );

   assign w_ext = (wb_select == WB_MEM) ? w_load : write_back_data;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_valid     <= 1'b0;
         r_fresh     <= 1'b0;
         r_reg_write <= 1'b0;
         r_rd        <= '0;
         r_data      <= '0;
         r_instret   <= '0;
      end else begin
         // fresh marks the single cycle an entry may write/retire
         if (flush) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
         end else if (stall) begin
            r_fresh <= 1'b0;
         end else begin
            r_valid     <= in_valid;
            r_fresh     <= in_valid;
            r_reg_write <= reg_write;
            r_rd        <= rd;
            r_data      <= w_ext;
         end
         if (retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign w_wr_ok   = r_valid & r_reg_write & (r_rd != 5'd0);

   assign rf_we     = r_fresh & w_wr_ok;
   assign rf_waddr  = r_rd;
   assign rf_wdata  = r_data;
   assign fwd_valid = w_wr_ok;
   assign fwd_rd    = r_rd;
   assign fwd_data  = r_data;
   assign retire    = r_fresh & r_valid;
   assign instret   = r_instret;

endmodule
